// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and the write-request bundle used by the WB and MDU sides
// of the register-file write-port arbiter.
package regfile_wb_arbiter_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 1 << AW;

  typedef struct packed {
    logic            we;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_wb_fifo.sv
// Small synchronous FIFO holding MDU results until the write port is free.
// A push only lands when the registered count shows room; pops never free a slot early.
module regfile_wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  wr_req_t push_req,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output wr_req_t head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]   addr_q [DEPTH];
  logic [AW-1:0]   addr_d [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] data_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            push_ok_s, pop_ok_s;

  // Next-state for storage, pointers and occupancy count.
  always_comb begin
    full      = (cnt_q == CW'(DEPTH));
    empty     = (cnt_q == {CW{1'b0}});
    push_ok_s = push_req.we && !full;
    pop_ok_s  = pop && !empty;
    addr_d    = addr_q;
    data_d    = data_q;
    if (push_ok_s) begin
      addr_d[wr_ptr_q] = push_req.addr;
      data_d[wr_ptr_q] = push_req.data;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    head.we   = !empty;
    head.addr = addr_q[rd_ptr_q];
    head.data = data_q[rd_ptr_q];
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= {AW{1'b0}};
        data_q[i] <= {XLEN{1'b0}};
      end
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      cnt_q    <= {CW{1'b0}};
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file write port between pipeline WB (fixed priority)
// and queued MDU results, with starvation hold and a busy-bit scoreboard for ID.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pl_we,
  input  logic [AW-1:0]   pl_rd,
  input  logic [XLEN-1:0] pl_wd,
  input  logic            mdu_valid,
  output logic            mdu_ready,
  input  logic [AW-1:0]   mdu_rd,
  input  logic [XLEN-1:0] mdu_wd,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            busy_rs1,
  output logic            busy_rs2,
  output logic            pl_hold,
  output logic            rf_we,
  output logic [AW-1:0]   rf_a3,
  output logic [XLEN-1:0] rf_wd,
  output logic            waw_err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wr_req_t         wb_req_s, push_req_s, head_s, grant_s;
  logic            fifo_full_s, fifo_empty_s, mdu_grant_s;
  logic [SW-1:0]   starve_q, starve_d;
  logic            pl_hold_q, pl_hold_d;
  logic            waw_err_q, waw_err_d;
  logic [NREG-1:0] busy_q, busy_d;

  // x0 results are acknowledged but never queued.
  always_comb begin
    push_req_s.we   = mdu_valid && (mdu_rd != {AW{1'b0}});
    push_req_s.addr = mdu_rd;
    push_req_s.data = mdu_wd;
  end

  regfile_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_req (push_req_s),
    .pop      (mdu_grant_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .head     (head_s)
  );

  // Same-cycle grant: WB always wins, otherwise the FIFO head is written.
  always_comb begin
    wb_req_s.we   = pl_we && (pl_rd != {AW{1'b0}});
    wb_req_s.addr = pl_rd;
    wb_req_s.data = pl_wd;
    mdu_grant_s   = rst && !wb_req_s.we && !fifo_empty_s;
    if (!rst) begin
      grant_s.we   = 1'b0;
      grant_s.addr = {AW{1'b0}};
      grant_s.data = {XLEN{1'b0}};
    end else if (wb_req_s.we) begin
      grant_s = wb_req_s;
    end else if (!fifo_empty_s) begin
      grant_s = head_s;
    end else begin
      grant_s.we   = 1'b0;
      grant_s.addr = {AW{1'b0}};
      grant_s.data = {XLEN{1'b0}};
    end
  end

  // Starvation counter, hold request, WAW flag and scoreboard next-state.
  always_comb begin
    if (fifo_empty_s || mdu_grant_s) begin
      starve_d = {SW{1'b0}};
    end else if (starve_q != SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
    if (mdu_grant_s) begin
      pl_hold_d = 1'b0;
    end else if (starve_q == SW'(STARVE_LIMIT)) begin
      pl_hold_d = 1'b1;
    end else begin
      pl_hold_d = pl_hold_q;
    end
    if (wb_req_s.we && busy_q[pl_rd]) begin
      waw_err_d = 1'b1;
    end else begin
      waw_err_d = waw_err_q;
    end
    busy_d = busy_q;
    if (mdu_grant_s) begin
      busy_d[head_s.addr] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    // Set after clear so a same-cycle reissue keeps the register busy.
    if (iss_valid) begin
      busy_d[iss_rd] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q  <= {SW{1'b0}};
      pl_hold_q <= 1'b0;
      waw_err_q <= 1'b0;
      busy_q    <= {NREG{1'b0}};
    end else begin
      starve_q  <= starve_d;
      pl_hold_q <= pl_hold_d;
      waw_err_q <= waw_err_d;
      busy_q    <= busy_d;
    end
  end

  assign mdu_ready = !fifo_full_s;
  assign busy_rs1  = busy_q[rs1];
  assign busy_rs2  = busy_q[rs2];
  assign pl_hold   = pl_hold_q;
  assign waw_err   = waw_err_q;
  assign rf_we     = grant_s.we;
  assign rf_a3     = grant_s.addr;
  assign rf_wd     = grant_s.data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pl_we, mdu_valid, iss_valid;
  logic [4:0]  pl_rd, mdu_rd, iss_rd, rs1, rs2;
  logic [31:0] pl_wd, mdu_wd;
  logic        mdu_ready, busy_rs1, busy_rs2, pl_hold, rf_we, waw_err;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;

  int n_vec = 0;
  int n_err = 0;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .pl_we(pl_we), .pl_rd(pl_rd), .pl_wd(pl_wd),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_wd(mdu_wd),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
    .busy_rs1(busy_rs1), .busy_rs2(busy_rs2), .pl_hold(pl_hold),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .waw_err(waw_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct { logic [4:0] rd; logic [31:0] wd; } res_t;
  res_t mq[$];
  bit   mbusy [32];
  int   mstarve;
  bit   mhold, mwaw;

  task automatic model_reset();
    mq.delete();
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    mstarve = 0; mhold = 1'b0; mwaw = 1'b0;
  endtask

  task automatic model_step();
    bit wb, grant, ready, was_empty;
    res_t r;
    wb        = pl_we && (pl_rd != 5'd0);
    was_empty = (mq.size() == 0);
    grant     = !wb && !was_empty;
    ready     = (mq.size() < 2);
    if (wb && mbusy[pl_rd]) mwaw = 1'b1;
    if (grant) mhold = 1'b0;
    else if (mstarve == 4) mhold = 1'b1;
    if (was_empty || grant) mstarve = 0;
    else if (mstarve < 4) mstarve = mstarve + 1;
    if (grant) begin
      mbusy[mq[0].rd] = 1'b0;
      void'(mq.pop_front());
    end
    if (mdu_valid && ready && mdu_rd != 5'd0) begin
      r.rd = mdu_rd; r.wd = mdu_wd;
      mq.push_back(r);
    end
    if (iss_valid && iss_rd != 5'd0) mbusy[iss_rd] = 1'b1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    bit wb;
    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    wb = pl_we && (pl_rd != 5'd0);
    if (wb) begin e_we = 1'b1; e_a3 = pl_rd; e_wd = pl_wd; end
    else if (mq.size() > 0) begin e_we = 1'b1; e_a3 = mq[0].rd; e_wd = mq[0].wd; end
    else begin e_we = 1'b0; e_a3 = 5'd0; e_wd = 32'd0; end
    chk("rnd_rf_we", {31'd0, rf_we}, {31'd0, e_we});
    chk("rnd_rf_a3", {27'd0, rf_a3}, {27'd0, e_a3});
    chk("rnd_rf_wd", rf_wd, e_wd);
    chk("rnd_mdu_ready", {31'd0, mdu_ready}, {31'd0, mq.size() < 2});
    chk("rnd_busy_rs1", {31'd0, busy_rs1}, {31'd0, mbusy[rs1]});
    chk("rnd_busy_rs2", {31'd0, busy_rs2}, {31'd0, mbusy[rs2]});
    chk("rnd_pl_hold", {31'd0, pl_hold}, {31'd0, mhold});
    chk("rnd_waw_err", {31'd0, waw_err}, {31'd0, mwaw});
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    pl_we = 1'b0; pl_rd = 5'd0; pl_wd = 32'd0;
    mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_wd = 32'd0;
    iss_valid = 1'b0; iss_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
  endtask

  // Advance one clock, stepping the model with this cycle's inputs.
  task automatic next();
    model_step();
    @(posedge clk); #1;
    idle();
  endtask

  // Enter reset, hold two cycles, release at posedge+1.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idle();
  endtask

  typedef struct {
    logic pl_we; logic [4:0] pl_rd; logic [31:0] pl_wd;
    logic mdu_valid; logic [4:0] mdu_rd; logic [31:0] mdu_wd;
    logic iss_valid; logic [4:0] iss_rd; logic [4:0] rs1, rs2;
    logic e_we; logic [4:0] e_a3; logic [31:0] e_wd;
    logic e_ready, e_b1, e_b2, e_hold, e_waw;
  } vec_t;

  vec_t tbl [10];

  function automatic vec_t mk(input logic pwe, input logic [4:0] prd, input logic [31:0] pwd,
                              input logic mv, input logic [4:0] mrd, input logic [31:0] mwd,
                              input logic iv, input logic [4:0] ird, input logic [4:0] r1, input logic [4:0] r2,
                              input logic ewe, input logic [4:0] ea3, input logic [31:0] ewd,
                              input logic erdy, input logic eb1, input logic eb2, input logic eh, input logic ew);
    vec_t v;
    v.pl_we = pwe; v.pl_rd = prd; v.pl_wd = pwd;
    v.mdu_valid = mv; v.mdu_rd = mrd; v.mdu_wd = mwd;
    v.iss_valid = iv; v.iss_rd = ird; v.rs1 = r1; v.rs2 = r2;
    v.e_we = ewe; v.e_a3 = ea3; v.e_wd = ewd;
    v.e_ready = erdy; v.e_b1 = eb1; v.e_b2 = eb2; v.e_hold = eh; v.e_waw = ew;
    return v;
  endfunction

  initial begin
    idle();
    //          pwe prd   pwd           mv  mrd   mwd           iv  ird   rs1   rs2    we  a3    wd            rdy b1 b2 h  w
    tbl[0] = mk(0, 5'd0, 32'd0,        0, 5'd0, 32'd0,        1, 5'd5, 5'd5, 5'd0,  0, 5'd0, 32'd0,        1, 0, 0, 0, 0);
    tbl[1] = mk(0, 5'd0, 32'd0,        1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 5'd5, 5'd0,  0, 5'd0, 32'd0,        1, 1, 0, 0, 0);
    tbl[2] = mk(0, 5'd0, 32'd0,        0, 5'd0, 32'd0,        0, 5'd0, 5'd5, 5'd0,  1, 5'd5, 32'hDEADBEEF, 1, 1, 0, 0, 0);
    tbl[3] = mk(0, 5'd0, 32'd0,        0, 5'd0, 32'd0,        0, 5'd0, 5'd5, 5'd0,  0, 5'd0, 32'd0,        1, 0, 0, 0, 0);
    tbl[4] = mk(1, 5'd0, 32'h1234,     1, 5'd0, 32'h5678,     0, 5'd0, 5'd0, 5'd0,  0, 5'd0, 32'd0,        1, 0, 0, 0, 0);
    tbl[5] = mk(0, 5'd0, 32'd0,        0, 5'd0, 32'd0,        0, 5'd0, 5'd0, 5'd0,  0, 5'd0, 32'd0,        1, 0, 0, 0, 0);
    tbl[6] = mk(1, 5'd7, 32'h77,       0, 5'd0, 32'd0,        0, 5'd0, 5'd0, 5'd0,  1, 5'd7, 32'h77,       1, 0, 0, 0, 0);
    tbl[7] = mk(0, 5'd0, 32'd0,        0, 5'd0, 32'd0,        1, 5'd4, 5'd0, 5'd4,  0, 5'd0, 32'd0,        1, 0, 0, 0, 0);
    tbl[8] = mk(1, 5'd4, 32'h44,       0, 5'd0, 32'd0,        0, 5'd0, 5'd0, 5'd4,  1, 5'd4, 32'h44,       1, 0, 1, 0, 0);
    tbl[9] = mk(0, 5'd0, 32'd0,        0, 5'd0, 32'd0,        0, 5'd0, 5'd0, 5'd4,  0, 5'd0, 32'd0,        1, 0, 1, 0, 1);

    // Reset with a WB request held: write suppressed, then granted at once.
    pl_we = 1'b1; pl_rd = 5'd3; pl_wd = 32'h33;
    #2;
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_pl_hold", {31'd0, pl_hold}, 32'd0);
    @(posedge clk); #1;
    model_reset();
    rst = 1'b1;
    #2;
    chk("post_rst_rf_we", {31'd0, rf_we}, 32'd1);
    chk("post_rst_rf_a3", {27'd0, rf_a3}, 32'd3);
    chk("post_rst_ready", {31'd0, mdu_ready}, 32'd1);
    chk("post_rst_busy", {30'd0, busy_rs1, busy_rs2}, 32'd0);
    chk("post_rst_waw", {31'd0, waw_err}, 32'd0);
    next();

    // Table-driven vectors.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      pl_we = tbl[i].pl_we; pl_rd = tbl[i].pl_rd; pl_wd = tbl[i].pl_wd;
      mdu_valid = tbl[i].mdu_valid; mdu_rd = tbl[i].mdu_rd; mdu_wd = tbl[i].mdu_wd;
      iss_valid = tbl[i].iss_valid; iss_rd = tbl[i].iss_rd; rs1 = tbl[i].rs1; rs2 = tbl[i].rs2;
      #2;
      chk($sformatf("tbl%0d_rf_we", i), {31'd0, rf_we}, {31'd0, tbl[i].e_we});
      chk($sformatf("tbl%0d_rf_a3", i), {27'd0, rf_a3}, {27'd0, tbl[i].e_a3});
      chk($sformatf("tbl%0d_rf_wd", i), rf_wd, tbl[i].e_wd);
      chk($sformatf("tbl%0d_ready", i), {31'd0, mdu_ready}, {31'd0, tbl[i].e_ready});
      chk($sformatf("tbl%0d_busy", i), {30'd0, busy_rs1, busy_rs2}, {30'd0, tbl[i].e_b1, tbl[i].e_b2});
      chk($sformatf("tbl%0d_hold", i), {31'd0, pl_hold}, {31'd0, tbl[i].e_hold});
      chk($sformatf("tbl%0d_waw", i), {31'd0, waw_err}, {31'd0, tbl[i].e_waw});
      next();
    end
    // WAW flag is sticky until reset.
    repeat (3) begin
      #2 chk("waw_sticky", {31'd0, waw_err}, 32'd1);
      next();
    end
    rst = 1'b0;
    #2 chk("waw_cleared_by_rst", {31'd0, waw_err}, 32'd0);
    chk("rst_forces_rf_we0", {31'd0, rf_we}, 32'd0);
    model_reset();
    @(posedge clk); #1 rst = 1'b1;

    // Contention: WB hogs the port while two MDU results queue.
    do_reset();
    pl_we = 1'b1; pl_rd = 5'd7; pl_wd = 32'h70;
    mdu_valid = 1'b1; mdu_rd = 5'd10; mdu_wd = 32'hA0A0;
    #2 chk("cont_wb_first", {27'd0, rf_a3}, 32'd7);
    next();
    pl_we = 1'b1; pl_rd = 5'd7; pl_wd = 32'h71;
    mdu_valid = 1'b1; mdu_rd = 5'd11; mdu_wd = 32'hB1B1;
    #2 chk("cont_ready_one", {31'd0, mdu_ready}, 32'd1);
    next();
    for (int c = 2; c <= 5; c++) begin
      pl_we = 1'b1; pl_rd = 5'd7; pl_wd = 32'h70 + c;
      #2;
      chk("cont_ready_full", {31'd0, mdu_ready}, 32'd0);
      chk("cont_hold_low", {31'd0, pl_hold}, 32'd0);
      chk("cont_wb_wins", {27'd0, rf_a3}, 32'd7);
      next();
    end
    #2;
    chk("cont_hold_high", {31'd0, pl_hold}, 32'd1);
    chk("cont_head_we", {31'd0, rf_we}, 32'd1);
    chk("cont_head_a3", {27'd0, rf_a3}, 32'd10);
    chk("cont_head_wd", rf_wd, 32'hA0A0);
    next();
    #2;
    chk("cont_hold_fall", {31'd0, pl_hold}, 32'd0);
    chk("cont_second_a3", {27'd0, rf_a3}, 32'd11);
    chk("cont_second_wd", rf_wd, 32'hB1B1);
    chk("cont_ready_back", {31'd0, mdu_ready}, 32'd1);
    next();
    #2 chk("cont_drained", {31'd0, rf_we}, 32'd0);
    next();

    // Same-cycle set and clear of one busy bit: set wins.
    do_reset();
    iss_valid = 1'b1; iss_rd = 5'd9;
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_wd = 32'h99;
    next();
    iss_valid = 1'b1; iss_rd = 5'd9; rs1 = 5'd9;
    #2;
    chk("sc_grant_a3", {27'd0, rf_a3}, 32'd9);
    chk("sc_busy_before", {31'd0, busy_rs1}, 32'd1);
    next();
    rs1 = 5'd9;
    #2 chk("sc_busy_kept", {31'd0, busy_rs1}, 32'd1);
    next();

    // Mid-operation reset discards a queued result.
    do_reset();
    pl_we = 1'b1; pl_rd = 5'd7; pl_wd = 32'h1;
    mdu_valid = 1'b1; mdu_rd = 5'd12; mdu_wd = 32'hC;
    next();
    do_reset();
    #2;
    chk("midrst_no_write", {31'd0, rf_we}, 32'd0);
    chk("midrst_ready", {31'd0, mdu_ready}, 32'd1);
    next();

    // Randomized run against the reference model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      pl_we     = (mhold && $urandom_range(0, 3) != 0) ? 1'b0 : ($urandom_range(0, 1) == 1);
      pl_rd     = 5'($urandom_range(0, 7));
      pl_wd     = $urandom;
      mdu_valid = ($urandom_range(0, 2) == 0);
      mdu_rd    = 5'($urandom_range(0, 7));
      mdu_wd    = $urandom;
      iss_valid = ($urandom_range(0, 3) == 0);
      iss_rd    = 5'($urandom_range(0, 7));
      rs1       = 5'($urandom_range(0, 7));
      rs2       = 5'($urandom_range(0, 7));
      #2 chk_model();
      next();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
